// File: rtl/mips_defs.sv
//------------------------------------------------------------------------------
// Module   : mips_defs (package)
// Brief    : Store-type encodings shared by the controller and the MEM stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_defs;

    typedef enum logic [1:0] {
        ST_WORD = 2'b00,
        ST_HALF = 2'b01,
        ST_BYTE = 2'b10,
        ST_NONE = 2'b11
    } store_type_e;

    localparam int unsigned LANES = 4;

endpackage

`default_nettype wire

// File: rtl/store_align.sv
//------------------------------------------------------------------------------
// Module   : store_align
// Brief    : Maps sw/sh/sb register data onto byte lanes and flags misalignment.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module store_align
    import mips_defs::*;
(
    input  logic [1:0]  storeType,
    input  logic [1:0]  addr,
    input  logic [31:0] WD,
    output logic [3:0]  mask,
    output logic [31:0] data,
    output logic        misaligned
);

    always_comb begin
        mask       = 4'b0000;
        data       = WD;
        misaligned = 1'b0;
        case (storeType)
            ST_WORD: begin
                if (addr != 2'b00) misaligned = 1'b1;
                else               mask       = 4'b1111;
            end
            ST_HALF: begin
                data = {2{WD[15:0]}};
                if (addr[0]) misaligned = 1'b1;
                else         mask       = addr[1] ? 4'b1100 : 4'b0011;
            end
            ST_BYTE: begin
                data = {4{WD[7:0]}};
                mask = 4'b0001 << addr;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dm_store.sv
//------------------------------------------------------------------------------
// Module   : dm_store
// Brief    : MEM-stage data memory: byte-masked store merge, async raw-word read.
//            Optional store log enabled by defining DM_STORE_LOG_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dm_store
    import mips_defs::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_3,
    input  logic        memWE_3,
    input  logic [1:0]  storeType_3,
    input  logic [31:0] addr_3,
    input  logic [31:0] WD_3,
    output logic [31:0] memRD_3,
    output logic        addrErr_3,
    output logic [31:0] lastStoreAddr
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0]       mem_q [0:DEPTH-1];
    logic [31:0]       last_store_addr_q;
    logic [31:0]       last_store_addr_d;
    logic [31:0]       mem_word_d;

    logic [31:0]       w_offset;
    logic [ADDR_W-1:0] w_idx;
    logic [3:0]        w_mask;
    logic [31:0]       w_data;
    logic              w_misaligned;
    logic              w_commit;
    logic              w_unused;

    store_align u_store_align (
        .storeType  (storeType_3),
        .addr       (addr_3[1:0]),
        .WD         (WD_3),
        .mask       (w_mask),
        .data       (w_data),
        .misaligned (w_misaligned)
    );

    // Upper offset bits are dropped so addresses wrap modulo the depth.
    assign w_offset  = addr_3 - BASE_ADDR;
    assign w_idx     = w_offset[ADDR_W+1:2];
    assign w_unused  = ^{PC_3, w_offset[31:ADDR_W+2], w_offset[1:0]};

    assign memRD_3   = mem_q[w_idx];
    assign addrErr_3 = memWE_3 & w_misaligned;
    assign w_commit  = memWE_3 & (w_mask != 4'b0000);
    assign lastStoreAddr = last_store_addr_q;

    always_comb begin
        mem_word_d        = memRD_3;
        last_store_addr_d = last_store_addr_q;
        for (int l = 0; l < LANES; l++) begin
            if (w_mask[l]) mem_word_d[8*l +: 8] = w_data[8*l +: 8];
        end
        if (w_commit) last_store_addr_d = {addr_3[31:2], 2'b00};
    end

    // Reset clears the whole array in one edge and wins over any store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            last_store_addr_q <= '0;
        end else begin
            if (w_commit) mem_q[w_idx] <= mem_word_d;
            last_store_addr_q <= last_store_addr_d;
`ifdef DM_STORE_LOG_EN
            if (w_commit)
                $display("%d@%h: *%h <= %h", $time, PC_3, {addr_3[31:2], 2'b00}, mem_word_d);
`else
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_store.sv
//------------------------------------------------------------------------------
// Module   : tb_dm_store
// Brief    : Directed self-checking bench for dm_store.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dm_store;

    logic        clk;
    logic        reset;
    logic [31:0] PC_3;
    logic        memWE_3;
    logic [1:0]  storeType_3;
    logic [31:0] addr_3;
    logic [31:0] WD_3;
    logic [31:0] memRD_3;
    logic        addrErr_3;
    logic [31:0] lastStoreAddr;

    int n_cmp;
    int n_bad;

    dm_store u_dut (
        .clk           (clk),
        .reset         (reset),
        .PC_3          (PC_3),
        .memWE_3       (memWE_3),
        .storeType_3   (storeType_3),
        .addr_3        (addr_3),
        .WD_3          (WD_3),
        .memRD_3       (memRD_3),
        .addrErr_3     (addrErr_3),
        .lastStoreAddr (lastStoreAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Set up a store (or a plain read when we == 0); values settle after #1.
    task automatic drive(input logic we, input logic [1:0] st, input logic [31:0] a, input logic [31:0] d);
        memWE_3     = we;
        storeType_3 = st;
        addr_3      = a;
        WD_3        = d;
        PC_3        = PC_3 + 32'd4;
        #1;
    endtask

    task automatic read(input logic [31:0] a);
        drive(1'b0, 2'b00, a, 32'h0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b1; PC_3 = 32'h0040_0000;
        memWE_3 = 1'b0; storeType_3 = 2'b00; addr_3 = '0; WD_3 = '0;
        step(); step();
        reset = 1'b0;

        read(32'h000); check("rst_rd_0",   memRD_3, 32'h0);
        read(32'h004); check("rst_rd_4",   memRD_3, 32'h0);
        read(32'hFFC); check("rst_rd_ffc", memRD_3, 32'h0);
        check("rst_last", lastStoreAddr, 32'h0);

        drive(1'b1, 2'b00, 32'h10, 32'h1234_5678);
        check("sw_err", {31'b0, addrErr_3}, 32'h0);
        check("sw_no_bypass", memRD_3, 32'h0);
        step();
        drive(1'b1, 2'b10, 32'h11, 32'h0000_00AB); step();
        read(32'h10); check("sb_merge", memRD_3, 32'h1234_AB78);

        drive(1'b1, 2'b01, 32'h12, 32'h0000_CAFE); step();
        read(32'h10); check("sh_hi_merge", memRD_3, 32'hCAFE_AB78);
        check("last_10", lastStoreAddr, 32'h10);

        drive(1'b1, 2'b01, 32'h13, 32'h0000_1111);
        check("sh_mis_err", {31'b0, addrErr_3}, 32'h1);
        step();
        drive(1'b1, 2'b00, 32'h16, 32'h2222_2222);
        check("sw_mis_err", {31'b0, addrErr_3}, 32'h1);
        step();
        read(32'h10); check("mis_keep_10", memRD_3, 32'hCAFE_AB78);
        read(32'h14); check("mis_keep_14", memRD_3, 32'h0);
        check("mis_last", lastStoreAddr, 32'h10);

        drive(1'b1, 2'b10, 32'h17, 32'h0000_005A); step();
        read(32'h14); check("sb_lane3", memRD_3, 32'h5A00_0000);
        check("last_14", lastStoreAddr, 32'h14);

        drive(1'b1, 2'b11, 32'h14, 32'hFFFF_FFFF);
        check("rsv_err", {31'b0, addrErr_3}, 32'h0);
        step();
        read(32'h14); check("rsv_nowrite", memRD_3, 32'h5A00_0000);

        drive(1'b0, 2'b00, 32'h16, 32'h0);
        check("nowe_err", {31'b0, addrErr_3}, 32'h0);

        drive(1'b1, 2'b10, 32'h30, 32'h0000_0011); step();
        drive(1'b1, 2'b10, 32'h31, 32'h0000_0022); step();
        read(32'h30); check("b2b_sb", memRD_3, 32'h0000_2211);
        drive(1'b1, 2'b01, 32'h32, 32'h1234_BEEF); step();
        read(32'h30); check("sh_lo_keep", memRD_3, 32'hBEEF_2211);

        drive(1'b1, 2'b00, 32'h20, 32'hDEAD_BEEF);
        reset = 1'b1; step(); reset = 1'b0;
        read(32'h20); check("rst_drop", memRD_3, 32'h0);
        read(32'h10); check("rst_clear", memRD_3, 32'h0);
        check("rst_last2", lastStoreAddr, 32'h0);

        drive(1'b1, 2'b00, 32'h1000, 32'h0000_0001);
        check("wrap_old", memRD_3, 32'h0);
        step();
        read(32'h0); check("wrap_rd", memRD_3, 32'h0000_0001);
        check("wrap_last", lastStoreAddr, 32'h0000_1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
